// File: rtl/zorro3_slave_ctrl.sv
// Zorro III slave-cycle front end: strobe sync, address latch,
// board decode and merged DTACK with timeout backstop.
module zorro3_slave_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        FCS_n,
  input  logic [3:0]  DS_n,
  input  logic [31:0] ZADDR,
  input  logic        ZREAD,
  input  logic        ZLOCK,
  input  logic        configured,
  input  logic [7:0]  base_addr,
  input  logic        int_dtack,
  input  logic        ncr_ack,
  output logic        slave_cycle,
  output logic [27:0] ADDR,
  output logic        READ,
  output logic        LOCK,
  output logic        DOE,
  output logic        DTACK_n,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    IGNORE,
    WAIT_DS,
    WAIT_ACK,
    ACK
  } state_t;

  state_t state, next;

  logic          fcs_s1, fcs_s2;
  logic [3:0]    ds_s1, ds_s2;
  logic          ds_any;
  logic [3:0]    addr_top;
  logic          match;
  logic [CW-1:0] count;
  logic          cnt_clr;
  logic          cnt_inc;
  logic          tmo;
  logic          sel;

  assign ds_any = ~&ds_s2;
  assign match  = configured &&
                  ({addr_top, ADDR[27:24]} == base_addr);

  // Two-flop synchronizers for the asynchronous strobes
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      fcs_s1 <= 1'b1;
      fcs_s2 <= 1'b1;
      ds_s1  <= 4'hF;
      ds_s2  <= 4'hF;
    end else begin
      fcs_s1 <= FCS_n;
      fcs_s2 <= fcs_s1;
      ds_s1  <= DS_n;
      ds_s2  <= ds_s1;
    end
  end

  // Address phase latch: tracks the bus until FCS is seen low
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      addr_top <= '0;
      ADDR     <= '0;
      READ     <= 1'b0;
      LOCK     <= 1'b0;
    end else if (fcs_s1) begin
      addr_top <= ZADDR[31:28];
      ADDR     <= ZADDR[27:0];
      READ     <= ZREAD;
      LOCK     <= ZLOCK;
    end
  end

  // Next-state decode and counter control
  always_comb begin
    next    = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fcs_s2) next = DECODE;
      end
      DECODE: begin
        next = match ? WAIT_DS : IGNORE;
      end
      IGNORE: begin
        if (fcs_s2) next = IDLE;
      end
      WAIT_DS: begin
        if (fcs_s2) begin
          next = IDLE;
        end else if (ds_any) begin
          next    = WAIT_ACK;
          cnt_clr = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (fcs_s2) begin
          next = IDLE;
        end else if (int_dtack || ncr_ack) begin
          next = ACK;
        end else if (count == LAST) begin
          next = ACK;
          tmo  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ACK: begin
        if (fcs_s2) next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign sel = (next == WAIT_DS) ||
               (next == WAIT_ACK) ||
               (next == ACK);

  // State register and acknowledge timeout counter
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next;
      if (cnt_clr) count <= '0;
      else if (cnt_inc) count <= count + CW'(1);
    end
  end

  // Registered bus outputs derived from the next state
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      slave_cycle <= 1'b0;
      DOE         <= 1'b0;
      DTACK_n     <= 1'b1;
      timeout_err <= 1'b0;
    end else begin
      slave_cycle <= sel;
      DOE         <= sel && READ;
      DTACK_n     <= !(next == ACK);
      timeout_err <= tmo;
    end
  end

endmodule

// File: doc/zorro3_slave_ctrl.md
# zorro3_slave_ctrl

Zorro III slave-cycle front end for the A4092. It synchronises the raw bus strobes, latches the address phase of the AD bus, and decodes board selection against the autoconfig base. It produces the `slave_cycle`, `ADDR`, `READ` and `LOCK` qualifiers consumed by the interrupt-register block and the NCR access path. It also merges their acknowledges into a single bus `DTACK_n`, with a timeout backstop.

## Interface
- `TIMEOUT`, default 64: number of WAIT_ACK cycles before a forced acknowledge; legal range 2..1023.
- `CLK` in 1: system clock.
- `RESET_n` in 1: synchronous, active-low reset.
- `FCS_n` in 1: raw Zorro III full cycle strobe (asynchronous).
- `DS_n` in 4: raw data strobes (asynchronous).
- `ZADDR` in 32: AD bus, address phase.
- `ZREAD` in 1: raw bus READ.
- `ZLOCK` in 1: raw A1/Lock.
- `configured` in 1: autoconfig complete.
- `base_addr` in 8: autoconfig-assigned base, compared against `ZADDR[31:24]`.
- `int_dtack` in 1: synchronous acknowledge from the interrupt-register block.
- `ncr_ack` in 1: synchronous acknowledge from the NCR access path.
- `slave_cycle` out 1: board selected, cycle in progress.
- `ADDR` out 28: latched `ZADDR[27:0]`.
- `READ` out 1: latched `ZREAD`.
- `LOCK` out 1: latched `ZLOCK`.
- `DOE` out 1: data output enable for read cycles.
- `DTACK_n` out 1: bus acknowledge, active low.
- `timeout_err` out 1: one-cycle pulse when a forced acknowledge is issued.

## Operation
- `FCS_n` passes through a 2-flop synchronizer: `fcs_s1`, then `fcs_s2`. Each `DS_n` bit passes through its own 2-flop synchronizer. `ds_any` is 1 when any synchronised DS bit is low.
- The address latch loads `ZADDR`, `ZREAD` and `ZLOCK` on every edge where `fcs_s1` is 1. It freezes while `fcs_s1` is 0.
- `match` is true when `configured` is 1 and `latched[31:24] == base_addr`.
- States:
  - **IDLE**: when `fcs_s2` is 0, go to DECODE.
  - **DECODE** (1 cycle): if `match`, go to WAIT_DS; otherwise go to IGNORE.
  - **IGNORE**: when `fcs_s2` is 1, go to IDLE. No outputs are asserted in this state.
  - **WAIT_DS**: if `fcs_s2` is 1, go to IDLE (abort). Otherwise, if `ds_any` is 1, go to WAIT_ACK and clear the counter.
  - **WAIT_ACK**:
    - If `fcs_s2` is 1, go to IDLE (abort, no DTACK).
    - Else if `int_dtack` or `ncr_ack` is 1, go to ACK.
    - Else if `count == TIMEOUT-1`, go to ACK and pulse `timeout_err`.
    - Otherwise increment `count`.
  - **ACK**: hold until `fcs_s2` is 1, then go to IDLE.
- `slave_cycle` is 1 in WAIT_DS, WAIT_ACK and ACK.
- `DOE` is 1 in the same states when `READ` is 1.
- `DTACK_n` is 0 only in ACK.
- The counter is `$clog2(TIMEOUT)` bits wide and does not wrap; it is only compared while in WAIT_ACK.
- All outputs are registered.

## Timing
- Reset values (`RESET_n` = 0 on any edge):
  - state IDLE
  - `slave_cycle` 0, `DOE` 0
  - `DTACK_n` 1, `timeout_err` 0
  - `ADDR` 0, `READ` 0, `LOCK` 0
  - counter 0 and synchronizers 1
- Reset asserted mid-cycle drops `DTACK_n` and `slave_cycle` on the next edge.
- Edge k is the first edge that samples raw `FCS_n` low:
  - the address captured is `ZADDR` as sampled at edge k;
  - the state is DECODE after k+2;
  - `slave_cycle` and `DOE` are 1 after k+3 (on a match).
- DS low first sampled at edge j gives WAIT_ACK after j+2, provided the state was already WAIT_DS.
- An acknowledge seen at edge m gives `DTACK_n` = 0 after edge m.
- A timeout leaves WAIT_ACK after exactly `TIMEOUT` cycles in that state. `timeout_err` is high for the first ACK cycle only.
- If an acknowledge and the terminal count coincide, the acknowledge wins and `timeout_err` stays 0.
- If `fcs_s2` goes high and an acknowledge arrives on the same edge, the abort wins.
- Raw `FCS_n` first sampled high at edge r gives `DTACK_n`, `slave_cycle` and `DOE` deasserted after r+2.
- Back-to-back cycles require `fcs_s2` to be seen high for at least one edge before the next cycle starts.

## Test plan
- **Matched read:** `base_addr` = 0x40, `ZADDR` = 0x40900004, `ZREAD` = 1, FCS low at edge 0, DS low at edge 1, `int_dtack` 1 from edge 6 -> `ADDR` = 0x0900004, `slave_cycle`/`DOE` = 1 after edge 3, `DTACK_n` = 0 after edge 6, all released 2 edges after FCS high.
- **Address mismatch:** `ZADDR` = 0x41000000 -> `slave_cycle`, `DOE` and `DTACK_n` never assert; the FSM returns to IDLE after FCS high.
- **Unconfigured:** `configured` = 0 with a matching address -> no response.
- **Timeout:** `TIMEOUT` = 8, matched write, no acknowledge -> `DTACK_n` low exactly 8 cycles after WAIT_ACK entry, `timeout_err` a single pulse, `DOE` = 0 throughout.
- **Abort:** FCS raised during WAIT_ACK with `ncr_ack` arriving on the same synchronised edge -> no `DTACK_n`, FSM back in IDLE; the next cycle is decoded normally.
- **Reset mid-ACK:** `RESET_n` = 0 for one edge while `DTACK_n` = 0 -> all outputs at reset values after that edge; a new FCS cycle completes normally.
